// File: rtl/sc_steer_pkg.sv
// Shared steering definitions: FSM state encoding and shift command codes used by the
// steering controller and the car position register.
package sc_steer_pkg;

  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  // Both buttons pressed; a direction value only, never driven on the shift bus.
  localparam logic [1:0] DIR_BOTH    = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat,
    StLock
  } state_e;

endpackage

// File: rtl/sc_debounce.sv
// Two-flop synchronizer followed by a debouncer for one active-low pushbutton.
// The debounced level follows the synchronized level only after it has disagreed for
// DEBOUNCE_CYCLES consecutive cycles.
module sc_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 24
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic level_o
);

  localparam logic [CNT_WIDTH-1:0] CntLast =
      CNT_WIDTH'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [1:0]           sync_q, sync_d;
  logic                 level_q, level_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_ni};
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CntLast) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Reset to the released level so a held button still needs a full debounce.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/sc_steer_controller.sv
// Steering controller: debounces the left/right buttons and issues single-cycle shift
// pulses with hold-to-repeat (initial delay, then a fixed period), locking out on both.
module sc_steer_controller
  import sc_steer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_WIDTH       = 24
) (
  input  logic       SC_REGSHIFTER_CLOCK_50,
  input  logic       SC_REGSHIFTER_RESET_InLow,
  input  logic       SC_STEER_left_InLow,
  input  logic       SC_STEER_right_InLow,
  input  logic       SC_STEER_enable_InHigh,
  output logic [1:0] SC_STEER_shift_OutBus
);

  localparam logic [CNT_WIDTH-1:0] DelayLast =
      CNT_WIDTH'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] PeriodLast =
      CNT_WIDTH'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic left_lvl, right_lvl;
  logic [1:0] dir_in;

  state_e               state_q, state_d;
  logic [1:0]           dir_q, dir_d;
  logic [1:0]           shift_q, shift_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;

  sc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_debounce_left (
    .clk_i  (SC_REGSHIFTER_CLOCK_50),
    .rst_ni (SC_REGSHIFTER_RESET_InLow),
    .btn_ni (SC_STEER_left_InLow),
    .level_o(left_lvl)
  );

  sc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_debounce_right (
    .clk_i  (SC_REGSHIFTER_CLOCK_50),
    .rst_ni (SC_REGSHIFTER_RESET_InLow),
    .btn_ni (SC_STEER_right_InLow),
    .level_o(right_lvl)
  );

  // Debounced levels are active-low; bit 0 is left, bit 1 is right.
  assign dir_in  = {~right_lvl, ~left_lvl};
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    shift_d = SHIFT_NONE;
    cnt_d   = '0;

    if (!SC_STEER_enable_InHigh) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dir_in == SHIFT_LEFT || dir_in == SHIFT_RIGHT) begin
            dir_d   = dir_in;
            shift_d = dir_in;
            state_d = StDelay;
          end else if (dir_in == DIR_BOTH) begin
            state_d = StLock;
          end
        end
        StDelay, StRepeat: begin
          if (dir_in == DIR_BOTH) begin
            state_d = StLock;
          end else if (dir_in != dir_q) begin
            state_d = StIdle;
          end else if (cnt_q >= ((state_q == StDelay) ? DelayLast : PeriodLast)) begin
            shift_d = dir_q;
            state_d = StRepeat;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StLock: begin
          if (dir_in == SHIFT_NONE) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge SC_REGSHIFTER_CLOCK_50 or negedge SC_REGSHIFTER_RESET_InLow) begin
    if (!SC_REGSHIFTER_RESET_InLow) begin
      state_q <= StIdle;
      dir_q   <= SHIFT_NONE;
      shift_q <= SHIFT_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SC_STEER_shift_OutBus = shift_q;

endmodule

// File: tb/tb_sc_steer_controller.sv
// Directed bench for sc_steer_controller with short debounce/repeat timing.
module tb_sc_steer_controller;

  typedef struct {
    logic       left_n;
    logic       right_n;
    logic       en;
    logic [1:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       left_n;
  logic       right_n;
  logic       en;
  logic [1:0] shift;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  sc_steer_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .CNT_WIDTH      (8)
  ) dut (
    .SC_REGSHIFTER_CLOCK_50   (clk),
    .SC_REGSHIFTER_RESET_InLow(rst_n),
    .SC_STEER_left_InLow      (left_n),
    .SC_STEER_right_InLow     (right_n),
    .SC_STEER_enable_InHigh   (en),
    .SC_STEER_shift_OutBus    (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: shift=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic l, input logic r, input logic e, input logic [1:0] x);
    vec_t v;
    v.left_n  = l;
    v.right_n = r;
    v.en      = e;
    v.exp     = x;
    vecs.push_back(v);
  endtask

  // Holds reset with buttons released, checks the reset output, releases on a falling edge.
  task automatic do_reset(input string name);
    rst_n   = 1'b0;
    left_n  = 1'b1;
    right_n = 1'b1;
    en      = 1'b1;
    repeat (3) @(posedge clk);
    #1 check({name, " reset"}, shift, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // vecs[i] drives edge i+1; output sampled 1 time unit after that edge.
  task automatic run_table(input string name);
    do_reset(name);
    for (int i = 0; i < vecs.size(); i++) begin
      left_n  = vecs[i].left_n;
      right_n = vecs[i].right_n;
      en      = vecs[i].en;
      @(posedge clk);
      #1 check($sformatf("%s edge %0d", name, i + 1), shift, vecs[i].exp);
      @(negedge clk);
    end
    vecs.delete();
  endtask

  initial begin
    rst_n   = 1'b0;
    left_n  = 1'b1;
    right_n = 1'b1;
    en      = 1'b1;

    // Left held: pulses after edges 7, 17, 22, 27.
    for (int k = 1; k <= 30; k++)
      add(1'b0, 1'b1, 1'b1, (k == 7 || k == 17 || k == 22 || k == 27) ? 2'b01 : 2'b00);
    run_table("hold_left");

    // Bouncing left: low 3 edges, high 1 edge, never accepted.
    for (int k = 1; k <= 24; k++)
      add((k % 4) == 0, 1'b1, 1'b1, 2'b00);
    run_table("bounce");

    // Right held, left added at 10 -> lock; release at 26; left alone from 34.
    for (int k = 1; k <= 42; k++) begin
      logic l, r;
      logic [1:0] x;
      r = !(k < 26);
      l = !((k >= 10 && k < 26) || k >= 34);
      x = (k == 7) ? 2'b10 : (k == 40) ? 2'b01 : 2'b00;
      add(l, r, 1'b1, x);
    end
    run_table("lock");

    // Left held, enable low for edges 12..29.
    for (int k = 1; k <= 46; k++)
      add(1'b0, 1'b1, !(k >= 12 && k < 30),
          (k == 7 || k == 30 || k == 40 || k == 45) ? 2'b01 : 2'b00);
    run_table("enable");

    // Reset in the middle of REPEAT with left still held.
    do_reset("midreset");
    left_n = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      #1;
    end
    check("midreset pulse22", shift, 2'b01);
    #2 rst_n = 1'b0;
    #1 check("midreset async clear", shift, 2'b00);
    repeat (2) @(posedge clk);
    #1 check("midreset held", shift, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1 check($sformatf("midreset after edge %0d", k), shift, (k == 7) ? 2'b01 : 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_steer_controller.md
SC_STEER_CONTROLLER -- requirements
Module: sc_steer_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000; consecutive stable cycles (10 ms at 50 MHz) required to accept a button level change.
REQ-002 Parameter REPEAT_DELAY, default 12500000; cycles (250 ms) from the first shift pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 5000000; cycles (100 ms) between later auto-repeat pulses.
REQ-004 Parameter CNT_WIDTH, default 24; width of the debounce and repeat counters, and SHALL be able to hold every count parameter.
REQ-005 SC_REGSHIFTER_CLOCK_50  in  1  system clock, 50 MHz, all logic on its rising edge.
REQ-006 SC_REGSHIFTER_RESET_InLow  in  1  reset, asynchronous, active-low.
REQ-007 SC_STEER_left_InLow  in  1  raw left pushbutton, active-low, asynchronous to the clock.
REQ-008 SC_STEER_right_InLow  in  1  raw right pushbutton, active-low, asynchronous to the clock.
REQ-009 SC_STEER_enable_InHigh  in  1  game-running qualifier, synchronous.
REQ-010 SC_STEER_shift_OutBus  out  2  registered shift command to the car position register: 01 = left, 10 = right, 00 = hold; 11 is never driven.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the count.
REQ-012 Debounced direction d: 01 = left only pressed, 10 = right only pressed, 00 = none pressed, 11 = both pressed.
REQ-013 FSM states: IDLE, DELAY, REPEAT, LOCK; a direction register dir holds the latched direction.
REQ-014 IDLE: if enable=1 and d is 01 or 10, the block SHALL latch dir=d, emit one pulse, clear the repeat counter and go to DELAY; if d=11 it SHALL go to LOCK.
REQ-015 DELAY: when the repeat counter reaches REPEAT_DELAY-1, the block SHALL emit one pulse, clear the counter and go to REPEAT.
REQ-016 REPEAT: the block SHALL emit one pulse every REPEAT_PERIOD cycles while d==dir.
REQ-017 DELAY and REPEAT: if d==11 the block SHALL go to LOCK; if d is any other value not equal to dir, it SHALL go to IDLE; in both cases no pulse is emitted.
REQ-018 LOCK: no pulses SHALL be emitted; the block SHALL go to IDLE only when d==00.
REQ-019 A pulse SHALL be shift_OutBus=dir for exactly one cycle, registered, in the cycle after the deciding edge; otherwise the output SHALL be 00.
REQ-020 Latency: with a raw button held low from rising edge 1, the first pulse SHALL be visible after edge 3+DEBOUNCE_CYCLES.
REQ-021 enable=0 SHALL force IDLE, output 00 and repeat counter 0 on the next edge; debouncers keep running.
REQ-022 After enable returns to 1 with a button still held, the block SHALL treat it as a fresh press per REQ-014.
REQ-023 Counters SHALL saturate and never wrap; the repeat counter is cleared on every state change.

Reset
REQ-024 While SC_REGSHIFTER_RESET_InLow=0, the block SHALL hold: state=IDLE, dir=00, shift_OutBus=00, all counters 0, synchronizer and debounced levels 1 (released).
REQ-025 Reset deassertion while a button is held SHALL produce the first pulse only after full debounce, per REQ-020.

Structure
REQ-026 Shared package sc_steer_pkg SHALL hold the FSM state encodings and the shift codes SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10, SHIFT_NONE=2'b00, which the position register also uses.
REQ-027 One sub-module sc_debounce (synchronizer plus debounce counter, parameterised by DEBOUNCE_CYCLES) SHALL be instantiated twice, once per button.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, enable=1)
REQ-028 Left held low from edge 1 -> shift=01 for one cycle after edge 7, then after edges 17, 22 and 27; 00 at all other times.
REQ-029 Left low for 3 edges then high, repeated -> shift stays 00 throughout.
REQ-030 Right held, then left also pressed before edge 17 -> one 10 pulse, then LOCK with no pulses; both released, then left pressed -> a new 01 pulse after full debounce.
REQ-031 Left held, enable dropped at edge 12 and restored at edge 30 -> pulse at 7, 00 during disable, a new pulse one cycle after edge 30, repeat 10 cycles later.
REQ-032 Reset asserted mid-REPEAT with left held -> output 00 immediately; after release, the first pulse arrives 2+DEBOUNCE_CYCLES+1 edges later.
